// File: rtl/mdio_arbiter.sv
// mdio_arbiter
//   Two-requester round-robin front end for a single IEEE 802.3 clause-22
//   MDIO master. One frame is in flight at a time: preamble, start, opcode,
//   PHY and register address, turnaround, 16 data bits, then one idle gap
//   bit before the completion pulse.
//
// Parameters
//   MDC_DIV   clk cycles per MDC half-period (>= 2)
//   PRE_BITS  preamble length in bits (0..32)
//
// Ports
//   clk, reset            system clock, synchronous active-high reset
//   req_valid/req_ready   per-requester handshake (bit i = requester i)
//   req_write             1 = write, 0 = read
//   req_phy, req_reg      5-bit addresses, requester i at [5i+4:5i]
//   req_wdata             16-bit write data, requester i at [16i+15:16i]
//   rsp_valid             one-cycle completion pulse to the owning requester
//   rsp_rdata             read data (zero for writes), held until next pulse
//   busy                  high from the cycle after acceptance through rsp_valid
//   mdc                   management clock
//   mdio_out/mdio_oen     serial data and active-low output enable
//   mdio_in               sampled bus value
module mdio_arbiter #(
   parameter int MDC_DIV  = 25,
   parameter int PRE_BITS = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  req_valid,
   output logic [1:0]  req_ready,
   input  logic [1:0]  req_write,
   input  logic [9:0]  req_phy,
   input  logic [9:0]  req_reg,
   input  logic [31:0] req_wdata,
   output logic [1:0]  rsp_valid,
   output logic [15:0] rsp_rdata,
   output logic        busy,
   output logic        mdc,
   output logic        mdio_out,
   output logic        mdio_oen,
   input  logic        mdio_in
);

   localparam int              PH_W     = $clog2(2 * MDC_DIV);
   localparam logic [PH_W-1:0] PH_HIGH  = PH_W'(MDC_DIV);
   localparam logic [PH_W-1:0] PH_LAST  = PH_W'(2 * MDC_DIV - 1);
   localparam logic [4:0]      PRE_LAST = 5'((PRE_BITS == 0) ? 0 : PRE_BITS - 1);

   typedef enum logic [2:0] {IDLE, PRE, CMD, TA, DATA, GAP, DONE} state_t;

   state_t            state_reg, state_next;
   logic [PH_W-1:0]   phase_reg, phase_next;
   logic [4:0]        bit_reg, bit_next;
   logic              bit_end;
   logic              frame_next;

   logic [1:0]        grant;
   logic              wr_reg;
   logic [4:0]        phy_reg;
   logic [4:0]        regad_reg;
   logic [15:0]       wdata_reg;
   logic              owner_reg;
   logic              last_reg;      // index granted most recently
   logic [15:0]       shift_reg;
   logic [15:0]       rsp_rdata_reg;
   logic              mdc_reg;
   logic              mdio_out_reg;
   logic              mdio_oen_reg;

   logic [13:0]       cmd_word;
   logic              drv_out;
   logic              drv_oen;

   // Per-requester field views
   logic [4:0]        phy_sel   [2];
   logic [4:0]        regad_sel [2];
   logic [15:0]       wdata_sel [2];

   for (genvar gi = 0; gi < 2; gi++) begin : g_req
      assign phy_sel[gi]   = req_phy[5*gi +: 5];
      assign regad_sel[gi] = req_reg[5*gi +: 5];
      assign wdata_sel[gi] = req_wdata[16*gi +: 16];
   end

   // Round-robin grant, only offered while idle. On a tie the requester that
   // was not granted last wins.
   always_comb begin
      grant = 2'b00;
      if (state_reg == IDLE) begin
         if (req_valid[0] && (!req_valid[1] || last_reg))
            grant = 2'b01;
         else if (req_valid[1])
            grant = 2'b10;
      end
   end

   assign req_ready = grant;

   // Frame sequencing: phase counts clk cycles within a bit, bit counts bits
   // within the current field group.
   always_comb begin
      state_next = state_reg;
      phase_next = phase_reg;
      bit_next   = bit_reg;
      bit_end    = (phase_reg == PH_LAST);

      case (state_reg)
         IDLE: begin
            phase_next = '0;
            bit_next   = '0;
            if (grant != 2'b00)
               state_next = (PRE_BITS == 0) ? CMD : PRE;
         end
         PRE, CMD, TA, DATA, GAP: begin
            phase_next = bit_end ? '0 : phase_reg + PH_W'(1);
            if (bit_end) begin
               bit_next = bit_reg + 5'd1;
               case (state_reg)
                  PRE:  if (bit_reg == PRE_LAST) begin state_next = CMD;  bit_next = '0; end
                  CMD:  if (bit_reg == 5'd13)    begin state_next = TA;   bit_next = '0; end
                  TA:   if (bit_reg == 5'd1)     begin state_next = DATA; bit_next = '0; end
                  DATA: if (bit_reg == 5'd15)    begin state_next = GAP;  bit_next = '0; end
                  default: begin state_next = DONE; bit_next = '0; end
               endcase
            end
         end
         default: begin
            // DONE lasts one cycle
            state_next = IDLE;
            phase_next = '0;
            bit_next   = '0;
         end
      endcase
   end

   assign frame_next = (state_next == PRE) || (state_next == CMD) || (state_next == TA) ||
                       (state_next == DATA) || (state_next == GAP);

   // Pin values for the bit that starts next cycle. At the acceptance edge the
   // captured fields are not yet loaded, but the first bit is either preamble
   // or the leading ST zero, neither of which depends on them.
   always_comb begin
      cmd_word = {2'b01, (wr_reg ? 2'b01 : 2'b10), phy_reg, regad_reg};
      drv_out  = 1'b1;
      drv_oen  = 1'b1;
      case (state_next)
         PRE: drv_oen = 1'b0;
         CMD: begin
            drv_oen = 1'b0;
            drv_out = cmd_word[4'd13 - bit_next[3:0]];
         end
         TA: if (wr_reg) begin
            drv_oen = 1'b0;
            drv_out = ~bit_next[0];
         end
         DATA: if (wr_reg) begin
            drv_oen = 1'b0;
            drv_out = wdata_reg[4'd15 - bit_next[3:0]];
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg     <= IDLE;
         phase_reg     <= '0;
         bit_reg       <= '0;
         wr_reg        <= 1'b0;
         phy_reg       <= '0;
         regad_reg     <= '0;
         wdata_reg     <= '0;
         owner_reg     <= 1'b0;
         last_reg      <= 1'b1;
         shift_reg     <= '0;
         rsp_rdata_reg <= '0;
         mdc_reg       <= 1'b0;
         mdio_out_reg  <= 1'b1;
         mdio_oen_reg  <= 1'b1;
      end else begin
         state_reg <= state_next;
         phase_reg <= phase_next;
         bit_reg   <= bit_next;

         if (grant != 2'b00) begin
            wr_reg    <= req_write[grant[1]];
            phy_reg   <= phy_sel[grant[1]];
            regad_reg <= regad_sel[grant[1]];
            wdata_reg <= wdata_sel[grant[1]];
            owner_reg <= grant[1];
            last_reg  <= grant[1];
            shift_reg <= '0;
         end

         // Sample in the cycle mdc goes high
         if ((state_reg == DATA) && (phase_reg == PH_HIGH) && !wr_reg)
            shift_reg <= {shift_reg[14:0], mdio_in};

         if (state_next == DONE)
            rsp_rdata_reg <= wr_reg ? 16'h0000 : shift_reg;

         mdc_reg <= frame_next && (phase_next >= PH_HIGH);

         // Pins only move on the first cycle of a bit (mdc falling edge)
         if (phase_next == '0) begin
            mdio_out_reg <= drv_out;
            mdio_oen_reg <= drv_oen;
         end
      end
   end

   assign rsp_valid = (state_reg == DONE) ? (owner_reg ? 2'b10 : 2'b01) : 2'b00;
   assign rsp_rdata = rsp_rdata_reg;
   assign busy      = (state_reg != IDLE);
   assign mdc       = mdc_reg;
   assign mdio_out  = mdio_out_reg;
   assign mdio_oen  = mdio_oen_reg;

endmodule

// File: tb/tb_mdio_arbiter.sv
// tb_mdio_arbiter
//   Drives two mdio_arbiter instances (default parameters and MDC_DIV=2,
//   PRE_BITS=0) from shared stimulus; sel picks which one is observed.
module tb_mdio_arbiter;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic [1:0]  req_valid;
   logic [1:0]  req_write;
   logic [9:0]  req_phy;
   logic [9:0]  req_reg;
   logic [31:0] req_wdata;
   logic        mdio_in;

   logic [1:0]  b_ready, s_ready, b_rvalid, s_rvalid;
   logic [15:0] b_rdata, s_rdata;
   logic        b_busy, s_busy, b_mdc, s_mdc, b_out, s_out, b_oen, s_oen;

   logic        sel;
   logic [1:0]  ready, rvalid;
   logic [15:0] rdata;
   logic        bsy, mdc_o, mout, moen;

   assign ready  = sel ? s_ready  : b_ready;
   assign rvalid = sel ? s_rvalid : b_rvalid;
   assign rdata  = sel ? s_rdata  : b_rdata;
   assign bsy    = sel ? s_busy   : b_busy;
   assign mdc_o  = sel ? s_mdc    : b_mdc;
   assign mout   = sel ? s_out    : b_out;
   assign moen   = sel ? s_oen    : b_oen;

   mdio_arbiter dut_big (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(b_ready),
      .req_write(req_write), .req_phy(req_phy), .req_reg(req_reg), .req_wdata(req_wdata),
      .rsp_valid(b_rvalid), .rsp_rdata(b_rdata), .busy(b_busy), .mdc(b_mdc),
      .mdio_out(b_out), .mdio_oen(b_oen), .mdio_in(mdio_in)
   );

   mdio_arbiter #(.MDC_DIV(2), .PRE_BITS(0)) dut_small (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(s_ready),
      .req_write(req_write), .req_phy(req_phy), .req_reg(req_reg), .req_wdata(req_wdata),
      .rsp_valid(s_rvalid), .rsp_rdata(s_rdata), .busy(s_busy), .mdc(s_mdc),
      .mdio_out(s_out), .mdio_oen(s_oen), .mdio_in(mdio_in)
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Reference model state
   int rr_last;            // requester granted last
   bit exp_out [0:64];
   bit exp_oen [0:64];
   int exp_n;
   int last_wait;
   int last_w;
   int last_done_ofs;

   // Expected per-bit pin values of one frame, straight from the frame layout
   task automatic build_frame(input bit wr, input logic [4:0] phy, input logic [4:0] ra,
                              input logic [15:0] wd, input int p);
      logic [31:0] body;
      body  = {2'b01, (wr ? 2'b01 : 2'b10), phy, ra, 2'b10, wd};
      exp_n = p + 33;
      for (int k = 0; k < p; k++) begin
         exp_out[k] = 1'b1;
         exp_oen[k] = 1'b0;
      end
      for (int j = 0; j < 32; j++) begin
         exp_out[p+j] = body[31-j];
         exp_oen[p+j] = (!wr && j >= 14);
      end
      exp_out[p+32] = 1'b1;
      exp_oen[p+32] = 1'b1;
   endtask

   // Waits for a grant and follows one frame bit by bit against the model
   task automatic run_txn(input bit hold, input logic [15:0] phy_data);
      int d, p, w, t_acc, waited, dk;
      logic [1:0]  exp_rdy;
      logic [15:0] exp_rd;
      bit          wr;
      d = sel ? 2 : 25;
      p = sel ? 0 : 32;
      if (req_valid == 2'b01)      w = 0;
      else if (req_valid == 2'b10) w = 1;
      else                         w = (rr_last == 1) ? 0 : 1;
      exp_rdy = 2'b01 << w;
      waited = 0;
      @(negedge clk);
      while (ready === 2'b00 && waited < 20) begin
         waited++;
         @(negedge clk);
      end
      last_wait = waited;
      last_w    = w;
      total++;
      if (ready !== exp_rdy) begin
         $display("FAIL grant got=%b exp=%b", ready, exp_rdy);
         bad++;
         return;
      end
      t_acc = cyc;
      wr    = req_write[w];
      build_frame(wr, req_phy[5*w +: 5], req_reg[5*w +: 5], req_wdata[16*w +: 16], p);
      rr_last = w;
      exp_rd  = wr ? 16'h0000 : phy_data;

      for (int k = 0; k < exp_n; k++) begin
         for (int c = 0; c < 2*d; c++) begin
            @(posedge clk); #1;
            if (k == 0 && c == 0 && !hold) req_valid[w] = 1'b0;
            dk = k - p - 16;
            if (dk >= 0 && dk < 16 && c == d) mdio_in = phy_data[15-dk];
            else                              mdio_in = 1'($urandom);
            if (c == 0) begin
               total++;
               if (mdc_o !== 1'b0) begin
                  $display("FAIL mdc_low bit=%0d got=%b exp=0", k, mdc_o); bad++;
               end
               total++;
               if (moen !== exp_oen[k]) begin
                  $display("FAIL oen bit=%0d got=%b exp=%b", k, moen, exp_oen[k]); bad++;
               end
               if (!exp_oen[k] || k == exp_n - 1) begin
                  total++;
                  if (mout !== exp_out[k]) begin
                     $display("FAIL mdio_out bit=%0d got=%b exp=%b", k, mout, exp_out[k]); bad++;
                  end
               end
               total++;
               if (bsy !== 1'b1 || ready !== 2'b00 || rvalid !== 2'b00) begin
                  $display("FAIL in_frame bit=%0d busy=%b ready=%b rsp_valid=%b exp=1/00/00",
                           k, bsy, ready, rvalid); bad++;
               end
            end
            if (c == d - 1) begin
               total++;
               if (mdc_o !== 1'b0) begin
                  $display("FAIL mdc_late bit=%0d got=%b exp=0", k, mdc_o); bad++;
               end
            end
            if (c == d) begin
               total++;
               if (mdc_o !== 1'b1 || moen !== exp_oen[k]) begin
                  $display("FAIL mdc_high bit=%0d mdc=%b oen=%b exp=1/%b", k, mdc_o, moen, exp_oen[k]);
                  bad++;
               end
            end
         end
      end

      @(posedge clk); #1;
      last_done_ofs = cyc - t_acc;
      total++;
      if (rvalid !== exp_rdy || bsy !== 1'b1) begin
         $display("FAIL rsp_valid got=%b busy=%b exp=%b busy=1", rvalid, bsy, exp_rdy); bad++;
      end
      total++;
      if (rdata !== exp_rd) begin
         $display("FAIL rsp_rdata got=%h exp=%h", rdata, exp_rd); bad++;
      end
      @(posedge clk); #1;
      total++;
      if (rvalid !== 2'b00 || bsy !== 1'b0 || mdc_o !== 1'b0 || rdata !== exp_rd) begin
         $display("FAIL after_done rsp_valid=%b busy=%b mdc=%b rdata=%h exp=00/0/0/%h",
                  rvalid, bsy, mdc_o, rdata, exp_rd); bad++;
      end
      $display("txn grant=%0d write=%0b rdata=%h done_ofs=%0d", w, wr, rdata, last_done_ofs);
   endtask

   task automatic test_reset;
      reset     = 1'b1;
      req_valid = 2'b00;
      repeat (3) @(posedge clk);
      #1;
      total++;
      if (mdc_o !== 1'b0 || moen !== 1'b1 || mout !== 1'b1) begin
         $display("FAIL reset_pins mdc=%b oen=%b out=%b exp=0/1/1", mdc_o, moen, mout); bad++;
      end
      total++;
      if (rvalid !== 2'b00 || rdata !== 16'h0000 || bsy !== 1'b0 || ready !== 2'b00) begin
         $display("FAIL reset_rsp rsp_valid=%b rdata=%h busy=%b ready=%b exp=00/0000/0/00",
                  rvalid, rdata, bsy, ready); bad++;
      end
      reset   = 1'b0;
      rr_last = 1;
      @(posedge clk); #1;
      total++;
      if (mdc_o !== 1'b0 || bsy !== 1'b0) begin
         $display("FAIL post_reset mdc=%b busy=%b exp=0/0", mdc_o, bsy); bad++;
      end
      $display("reset sel=%0b done", sel);
   endtask

   task automatic test_write_default;
      req_write       = 2'b01;
      req_phy[4:0]    = 5'd1;
      req_reg[4:0]    = 5'd0;
      req_wdata[15:0] = 16'h1140;
      req_valid       = 2'b01;
      run_txn(1'b0, 16'h0000);
      total++;
      if (last_done_ofs !== 3251) begin
         $display("FAIL write_latency got=%0d exp=3251", last_done_ofs); bad++;
      end
   endtask

   task automatic test_read_default;
      req_write        = 2'b00;
      req_phy[9:5]     = 5'd0;
      req_reg[9:5]     = 5'd2;
      req_valid        = 2'b10;
      run_txn(1'b0, 16'h0141);
   endtask

   task automatic test_reset_mid_read;
      int waited, tgt;
      bit seen;
      req_write        = 2'b00;
      req_phy[4:0]     = 5'($urandom);
      req_reg[4:0]     = 5'($urandom);
      req_valid        = 2'b01;
      waited = 0;
      @(negedge clk);
      while (ready === 2'b00 && waited < 20) begin
         waited++;
         @(negedge clk);
      end
      total++;
      if (ready !== 2'b01) begin
         $display("FAIL mid_grant got=%b exp=01", ready); bad++;
      end
      tgt = 1 + (32 + 16 + 5) * 50 + 3;
      for (int i = 1; i <= tgt; i++) begin
         @(posedge clk); #1;
         if (i == 1) req_valid = 2'b00;
         mdio_in = 1'($urandom);
      end
      total++;
      if (bsy !== 1'b1 || moen !== 1'b1) begin
         $display("FAIL mid_frame busy=%b oen=%b exp=1/1", bsy, moen); bad++;
      end
      reset = 1'b1;
      @(posedge clk); #1;
      total++;
      if (mdc_o !== 1'b0 || moen !== 1'b1 || mout !== 1'b1 || bsy !== 1'b0 ||
          rvalid !== 2'b00 || rdata !== 16'h0000) begin
         $display("FAIL mid_reset mdc=%b oen=%b out=%b busy=%b rsp_valid=%b rdata=%h exp=0/1/1/0/00/0000",
                  mdc_o, moen, mout, bsy, rvalid, rdata); bad++;
      end
      reset   = 1'b0;
      rr_last = 1;
      seen    = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(posedge clk); #1;
         if (rvalid !== 2'b00 || mdc_o !== 1'b0) seen = 1'b1;
      end
      total++;
      if (seen) begin
         $display("FAIL aborted_frame activity=1 exp=0"); bad++;
      end
      $display("reset mid-read done");
      req_write        = 2'b10;
      req_phy[9:5]     = 5'($urandom);
      req_reg[9:5]     = 5'($urandom);
      req_wdata[31:16] = 16'($urandom);
      req_valid        = 2'b10;
      run_txn(1'b0, 16'h0000);
   endtask

   task automatic test_rr_tie;
      int exp_seq [4] = '{0, 1, 0, 1};
      req_write = 2'($urandom);
      req_phy   = 10'($urandom);
      req_reg   = 10'($urandom);
      req_wdata = $urandom;
      req_valid = 2'b11;
      for (int i = 0; i < 4; i++) begin
         run_txn(1'b1, 16'($urandom));
         total++;
         if (last_w !== exp_seq[i]) begin
            $display("FAIL rr_order idx=%0d got=%0d exp=%0d", i, last_w, exp_seq[i]); bad++;
         end
         if (i > 0) begin
            total++;
            if (last_wait !== 0) begin
               $display("FAIL back_to_back idx=%0d wait=%0d exp=0", i, last_wait); bad++;
            end
         end
      end
      req_valid = 2'b00;
   endtask

   task automatic test_small_timing;
      req_write       = 2'b01;
      req_phy[4:0]    = 5'($urandom);
      req_reg[4:0]    = 5'($urandom);
      req_wdata[15:0] = 16'($urandom);
      req_valid       = 2'b01;
      run_txn(1'b0, 16'h0000);
      total++;
      if (last_done_ofs !== 133) begin
         $display("FAIL small_latency got=%0d exp=133", last_done_ofs); bad++;
      end
   endtask

   task automatic test_no_grant;
      @(posedge clk); #1;
      req_valid = 2'b01;
      #2;
      total++;
      if (ready !== 2'b01) begin
         $display("FAIL idle_ready got=%b exp=01", ready); bad++;
      end
      req_valid = 2'b00;
      for (int i = 0; i < 60; i++) begin
         @(posedge clk); #1;
         total++;
         if (mdc_o !== 1'b0 || bsy !== 1'b0) begin
            $display("FAIL no_grant cyc=%0d mdc=%b busy=%b exp=0/0", i, mdc_o, bsy); bad++;
         end
      end
      $display("no-grant pulse done");
   endtask

   task automatic test_random;
      for (int n = 0; n < 12; n++) begin
         for (int i = 0; i < 2; i++) begin
            if (!req_valid[i]) begin
               req_valid[i]          = 1'($urandom);
               req_write[i]          = 1'($urandom);
               req_phy[5*i +: 5]     = 5'($urandom);
               req_reg[5*i +: 5]     = 5'($urandom);
               req_wdata[16*i +: 16] = 16'($urandom);
            end
         end
         if (req_valid == 2'b00) req_valid[n % 2] = 1'b1;
         run_txn(1'b0, 16'($urandom));
      end
      req_valid = 2'b00;
   endtask

   initial begin
      reset     = 1'b1;
      req_valid = 2'b00;
      req_write = 2'b00;
      req_phy   = '0;
      req_reg   = '0;
      req_wdata = '0;
      mdio_in   = 1'b1;
      sel       = 1'b0;
      rr_last   = 1;

      test_reset();
      test_write_default();
      test_read_default();
      test_reset_mid_read();

      sel = 1'b1;
      test_reset();
      test_rr_tie();
      test_small_timing();
      test_no_grant();
      test_random();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
